bus_arbiter_n: RTL and testbench
================================

# bus_arbiter_n

Parametrised N-master arbiter for the unidirectional shared bus. It grants bus ownership to exactly one requesting master at a time using fixed-priority or round-robin selection. It is non-preemptive, with an optional hold limit that forces re-arbitration so a long transfer cannot starve other masters. It sits between the master request lines and the bus address/data muxes, which are steered by `ack_id`.

## Interface
- `NUM_MASTERS`, 4: number of masters. Legal range 2..16.
- `MODE`, 0: arbitration policy.
  - 0 = fixed priority; highest index wins.
  - 1 = round-robin.
- `MAX_HOLD`, 0: maximum consecutive grant cycles while another master is waiting.
  - 0 = unlimited.
  - Legal range 0..255.
- `IDW`, derived: `$clog2(NUM_MASTERS)`, minimum 1. Not user-set.

Ports:
- `clk`  in  1  bus clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_MASTERS  request lines; bit i belongs to master i; level-sensitive.
- `ack`  out  NUM_MASTERS  registered grant; one-hot or all-zero.
- `ack_id`  out  IDW  binary index of the granted master; 0 when idle.
- `busy`  out  1  high when any `ack` bit is set.

## Operation
- Two states:
  - IDLE: `ack` = 0.
  - GRANT: `ack` one-hot at index `owner`.
- Reset (`reset` = 0) takes effect immediately, without waiting for a clock edge:
  - state = IDLE; `ack` = 0, `ack_id` = 0, `busy` = 0.
  - hold counter = 0.
  - RR pointer = NUM_MASTERS-1, so the first round-robin search starts at master 0.
- Selection function `pick(mask)` over request vector `mask`:
  - Fixed mode: highest set index.
  - RR mode: first set index searching upward from pointer+1, wrapping modulo NUM_MASTERS.
  - Empty mask: returns no grant.
- Behaviour in IDLE, at each edge:
  - `req` = 0: stay in IDLE.
  - Otherwise: grant `pick(req)`, go to GRANT, hold counter = 1.
- Behaviour in GRANT, at each edge:
  - Let `others` = `req` with the owner bit cleared.
  - Expired = (MAX_HOLD ≠ 0) and (hold counter ≥ MAX_HOLD) and (`others` ≠ 0).
  - Keep the grant when `req[owner]` = 1 and not expired. The hold counter increments, saturating at MAX_HOLD.
  - Owner dropped `req`: grant `pick(others)` in the same edge, with no dead cycle. If `others` = 0, go to IDLE.
  - Expired: grant `pick(others)`. The current owner is excluded for this decision only.
  - Any new grant resets the hold counter to 1.
- No preemption: a higher-priority request never removes a grant before the owner drops `req` or its hold expires.
- RR pointer is updated to the new owner index on every new grant. It is unchanged while a grant is kept or the arbiter is idle.
- A lone requester keeps the grant indefinitely. The hold limit applies only while another master is waiting.
- Handover is always one-hot to one-hot in a single edge. `ack` is never multi-hot.

## Timing
- Request-to-grant latency: one edge. `req[i]` is sampled high at edge k, and `ack[i]` is high after edge k.
- Release latency: one edge. `req[owner]` is sampled low at edge k, and `ack` changes after edge k.
- All outputs come directly from flops, with no combinational path from `req` to `ack`.
- `ack_id` and `busy` change in the same cycle as `ack`.
- Maximum wait for any continuously requesting master, in RR mode with MAX_HOLD = H > 0: (NUM_MASTERS-1)·H cycles after the current grant starts.
- Reset asserted mid-grant clears outputs asynchronously. Release is synchronous:
  - The first arbitration happens at the first edge after `reset` goes high.
  - That first arbitration behaves as arbitration from IDLE.

## Test plan
All scenarios use NUM_MASTERS = 4.
- Reset mid-grant:
  - Setup: MODE = 0, owner = 2, `reset` driven low between edges.
  - Required: `ack` = 0000, `ack_id` = 0, `busy` = 0 before the next edge.
  - After release with `req` = 0001: `ack` = 0001 after the first edge.
- Fixed priority, non-preemptive (MODE = 0, MAX_HOLD = 0):
  - `req` = 0101 → `ack` = 0100, `ack_id` = 2.
  - `req` = 1101 → `ack` stays 0100.
  - `req` = 1001 → `ack` = 1000 after one edge, with no idle cycle.
- Round-robin rotation (MODE = 1, MAX_HOLD = 2):
  - `req` = 1111 held constant.
  - `ack` sequence: 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000, 0001, …
- Hold expiry in fixed mode (MODE = 0, MAX_HOLD = 3):
  - `req` = 1001 held constant.
  - `ack` = 1000 for 3 cycles, then 0001 for 3 cycles, then 1000 again.
- Lone requester (MODE = 1, MAX_HOLD = 2):
  - `req` = 0010 held for 10 cycles → `ack` = 0010 for all 10 cycles.
  - Hold counter saturates at 2.
- Release to idle, then re-arbitration from idle (MODE = 1):
  - Owner 1 drops with `req` = 0000 → `ack` = 0000 and `busy` = 0 after one edge.
  - Next `req` = 0101 → `ack` = 0100, because the search starts from pointer+1 = 2.

Source files
------------

// File: rtl/bus_arbiter_n_if.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arbiter_n_if
//  Purpose  : Request/grant bundle between bus masters and bus_arbiter_n.
//             slave  = arbiter side (samples req, drives grant outputs)
//             master = requester side (drives req, observes grant outputs)
//  Revision : 1.0  initial release
// ============================================================================
interface bus_arbiter_n_if #(
    parameter int NUM_MASTERS = 4
);
    localparam int IDW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] ack;
    logic [IDW-1:0]         ack_id;
    logic                   busy;

    modport slave  (input  req, output ack, output ack_id, output busy);
    modport master (output req, input  ack, input  ack_id, input  busy);
endinterface
`default_nettype wire

// File: rtl/bus_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arbiter_n
//  Purpose  : Non-preemptive N-master bus arbiter, fixed-priority (highest
//             index wins) or round-robin, with an optional hold limit that
//             forces re-arbitration while other masters are waiting.
//             All outputs are registered; ack_id steers the bus muxes.
//  Revision : 1.0  initial release
// ============================================================================
module bus_arbiter_n #(
    parameter int NUM_MASTERS = 4,
    parameter int MODE        = 0,   // 0 = fixed priority, 1 = round-robin
    parameter int MAX_HOLD    = 0    // 0 = unlimited, else 1..255
) (
    input  wire logic        clk,
    input  wire logic        reset,  // asynchronous, active-low
    bus_arbiter_n_if.slave   bus
);
    localparam int         IDW      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t                 state, state_nx;
    logic [IDW-1:0]         owner, owner_nx;      // doubles as ack_id
    logic [IDW-1:0]         rr_ptr, rr_ptr_nx;
    logic [7:0]             hold_cnt, hold_cnt_nx;
    logic [NUM_MASTERS-1:0] ack_q, ack_nx;
    logic                   busy_q, busy_nx;

    logic [NUM_MASTERS-1:0] others;
    logic                   expired;
    logic [IDW:0]           pick_req;
    logic [IDW:0]           pick_oth;

    // Returns {found, index}. Fixed mode: highest set bit. RR mode: first set
    // bit at or after ptr+1 (wrapping); the loop runs from the farthest offset
    // down so the nearest match is the one left standing.
    function automatic logic [IDW:0] pick(input logic [NUM_MASTERS-1:0] mask,
                                          input logic [IDW-1:0]         ptr);
        logic [IDW:0]   r;
        logic [IDW-1:0] ii;
        r = '0;
        if (MODE == 0) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                ii = IDW'(i);
                if (mask[ii]) r = {1'b1, ii};
            end
        end else begin
            for (int k = NUM_MASTERS; k >= 1; k--) begin
                ii = IDW'((int'(ptr) + k) % NUM_MASTERS);
                if (mask[ii]) r = {1'b1, ii};
            end
        end
        return r;
    endfunction

    // Next-state, hold counter, RR pointer and next registered outputs.
    always_comb begin
        state_nx    = state;
        owner_nx    = owner;
        rr_ptr_nx   = rr_ptr;
        hold_cnt_nx = hold_cnt;
        ack_nx      = '0;
        busy_nx     = 1'b0;

        others        = bus.req;
        others[owner] = 1'b0;
        expired       = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LIM) && (|others);
        pick_req      = pick(bus.req, rr_ptr);
        pick_oth      = pick(others, rr_ptr);

        case (state)
            S_IDLE: begin
                if (pick_req[IDW]) begin
                    state_nx    = S_GRANT;
                    owner_nx    = pick_req[IDW-1:0];
                    rr_ptr_nx   = pick_req[IDW-1:0];
                    hold_cnt_nx = 8'd1;
                end
            end
            S_GRANT: begin
                if (bus.req[owner] && !expired) begin
                    // Keep grant; counter saturates (at 255 when unlimited).
                    if (MAX_HOLD != 0) begin
                        if (hold_cnt < HOLD_LIM) hold_cnt_nx = hold_cnt + 8'd1;
                    end else if (hold_cnt != 8'hFF) begin
                        hold_cnt_nx = hold_cnt + 8'd1;
                    end
                end else if (pick_oth[IDW]) begin
                    owner_nx    = pick_oth[IDW-1:0];
                    rr_ptr_nx   = pick_oth[IDW-1:0];
                    hold_cnt_nx = 8'd1;
                end else begin
                    state_nx    = S_IDLE;
                    owner_nx    = '0;
                    hold_cnt_nx = 8'd0;
                end
            end
            default: begin
                state_nx    = S_IDLE;
                owner_nx    = '0;
                hold_cnt_nx = 8'd0;
            end
        endcase

        if (state_nx == S_GRANT) begin
            ack_nx[owner_nx] = 1'b1;
            busy_nx          = 1'b1;
        end
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            owner    <= '0;
            rr_ptr   <= IDW'(NUM_MASTERS - 1);
            hold_cnt <= 8'd0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            owner    <= owner_nx;
            rr_ptr   <= rr_ptr_nx;
            hold_cnt <= hold_cnt_nx;
            ack_q    <= ack_nx;
            busy_q   <= busy_nx;
        end
    end

    assign bus.ack    = ack_q;
    assign bus.ack_id = owner;
    assign bus.busy   = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_arbiter_n
//  Purpose  : Directed bench for bus_arbiter_n with three configurations:
//             A = fixed/unlimited, B = round-robin/hold 2, C = fixed/hold 3.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_arbiter_n;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bus_arbiter_n_if #(.NUM_MASTERS(4)) if_a ();
    bus_arbiter_n_if #(.NUM_MASTERS(4)) if_b ();
    bus_arbiter_n_if #(.NUM_MASTERS(4)) if_c ();

    bus_arbiter_n #(.NUM_MASTERS(4), .MODE(0), .MAX_HOLD(0)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
    bus_arbiter_n #(.NUM_MASTERS(4), .MODE(1), .MAX_HOLD(2)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
    bus_arbiter_n #(.NUM_MASTERS(4), .MODE(0), .MAX_HOLD(3)) dut_c (.clk(clk), .reset(reset), .bus(if_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rr_seq [9];
    logic [3:0] hc_seq [7];

    initial begin
        rr_seq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                   4'b0100, 4'b1000, 4'b1000, 4'b0001};
        hc_seq = '{4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b1000};
        if_a.req = '0;
        if_b.req = '0;
        if_c.req = '0;

        // Reset state
        step();
        step();
        check("rst_ack_a",  32'(if_a.ack),    32'h0);
        check("rst_id_a",   32'(if_a.ack_id), 32'h0);
        check("rst_busy_a", 32'(if_a.busy),   32'h0);
        check("rst_ack_b",  32'(if_b.ack),    32'h0);
        @(negedge clk);
        reset = 1'b1;
        step();
        check("idle_ack_a", 32'(if_a.ack),    32'h0);

        // Fixed priority, non-preemptive (A)
        if_a.req = 4'b0101;
        step();
        check("fp_ack_0101",  32'(if_a.ack),    32'b0100);
        check("fp_id_0101",   32'(if_a.ack_id), 32'd2);
        check("fp_busy_0101", 32'(if_a.busy),   32'h1);
        if_a.req = 4'b1101;
        step();
        check("fp_nopreempt1", 32'(if_a.ack), 32'b0100);
        step();
        check("fp_nopreempt2", 32'(if_a.ack), 32'b0100);
        if_a.req = 4'b1001;
        step();
        check("fp_handover_ack", 32'(if_a.ack),    32'b1000);
        check("fp_handover_id",  32'(if_a.ack_id), 32'd3);
        check("fp_handover_bsy", 32'(if_a.busy),   32'h1);

        // Reset mid-grant (A, owner 2)
        if_a.req = 4'b0100;
        step();
        step();
        check("mg_pre_ack", 32'(if_a.ack), 32'b0100);
        #2 reset = 1'b0;
        #1;
        check("mg_rst_ack",  32'(if_a.ack),    32'h0);
        check("mg_rst_id",   32'(if_a.ack_id), 32'h0);
        check("mg_rst_busy", 32'(if_a.busy),   32'h0);
        if_a.req = 4'b0001;
        @(negedge clk);
        reset = 1'b1;
        step();
        check("mg_rel_ack", 32'(if_a.ack),    32'b0001);
        check("mg_rel_id",  32'(if_a.ack_id), 32'd0);

        // Round-robin rotation with hold 2 (B)
        if_b.req = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("rr_rot_%0d", i), 32'(if_b.ack), 32'(rr_seq[i]));
        end

        // Lone requester keeps grant (B)
        if_b.req = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("lone_%0d", i), 32'(if_b.ack), 32'b0010);
        end
        check("lone_id", 32'(if_b.ack_id), 32'd1);

        // Release to idle then re-arbitrate from pointer+1 (B)
        if_b.req = 4'b0000;
        step();
        check("rel_ack",  32'(if_b.ack),    32'h0);
        check("rel_busy", 32'(if_b.busy),   32'h0);
        check("rel_id",   32'(if_b.ack_id), 32'h0);
        if_b.req = 4'b0101;
        step();
        check("rearb_ack", 32'(if_b.ack),    32'b0100);
        check("rearb_id",  32'(if_b.ack_id), 32'd2);

        // Hold expiry in fixed mode (C)
        if_c.req = 4'b1001;
        for (int i = 0; i < 7; i++) begin
            step();
            check($sformatf("hold_%0d", i), 32'(if_c.ack), 32'(hc_seq[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
